// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: relation codes, FSM states and types shared by the serial comparator.
package serial_cmp_pkg;
  typedef logic [1:0] cmp_rel_t;
  localparam cmp_rel_t CMP_EQ = 2'b00;
  localparam cmp_rel_t CMP_LT = 2'b01;
  localparam cmp_rel_t CMP_GT = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_cmp_bit_step.sv
// serial_cmp_bit_step: one LSB-first compare step; a differing bit overrides the relation so far.
module serial_cmp_bit_step
  import serial_cmp_pkg::*;
(
  input  cmp_rel_t prev,
  input  logic     a_bit,
  input  logic     b_bit,
  input  logic     is_sign_bit,
  output cmp_rel_t next
);
  // The sign bit carries negative weight, so a set A bit there means A is smaller.
  assign next = (a_bit == b_bit) ? prev : ((is_sign_bit ? a_bit : b_bit) ? CMP_LT : CMP_GT);
endmodule

// File: rtl/serial_signed_comparator.sv
// serial_signed_comparator: bit-serial LSB-first two's-complement comparator with valid/ready handshakes.
// Defining SERIAL_CMP_UNSIGNED_EN adds an is_signed input selecting signed or unsigned compare.
module serial_signed_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_CMP_UNSIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output cmp_rel_t         ans,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state, next_state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] count;
  cmp_rel_t rel, step_rel;
  logic signed_q, last;
  assign last = count == CW'(WIDTH - 1);
  serial_cmp_bit_step u_step (
    .prev       (rel),
    .a_bit      (sa[0]),
    .b_bit      (sb[0]),
    .is_sign_bit(last && signed_q),
    .next       (step_rel)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    case (state)
      IDLE: next_state = in_valid ? RUN : IDLE;
      RUN: next_state = last ? DONE : RUN;
      DONE: next_state = out_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      count <= '0;
      rel <= CMP_EQ;
      ans <= CMP_EQ;
      signed_q <= 1'b1;
    end else if (state == IDLE && in_valid) begin
      sa <= a;
      sb <= b;
      count <= '0;
      rel <= CMP_EQ;
`ifdef SERIAL_CMP_UNSIGNED_EN
      signed_q <= is_signed;
`else
      signed_q <= 1'b1;
`endif
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      rel <= step_rel;
      count <= last ? count : count + 1'b1;
      if (last) ans <= step_rel;
    end
  end
endmodule

// File: tb/tb_serial_signed_comparator.sv
// tb_serial_signed_comparator: table-driven and scoreboard-checked bench for the serial comparator.
module tb_serial_signed_comparator;
  import serial_cmp_pkg::*;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  cmp_rel_t ans;
`ifdef SERIAL_CMP_UNSIGNED_EN
  logic is_signed = 1'b1;
`endif
  serial_signed_comparator #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef SERIAL_CMP_UNSIGNED_EN
    .is_signed(is_signed),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ans      (ans),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    cmp_rel_t     r;
  } vec_t;
  vec_t tbl[12];
  cmp_rel_t q[$];
  int vecs = 0, errs = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic cmp_rel_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    return $signed(x) < $signed(y) ? CMP_LT : ($signed(x) > $signed(y) ? CMP_GT : CMP_EQ);
  endfunction
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input cmp_rel_t r);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    q.push_back(r);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("run_handshake", {busy, in_ready}, 2'b10);
  endtask
  task automatic get_result(input string nm, input int exp_lat, input int hold);
    int lat = 0;
    cmp_rel_t exp;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, exp_lat);
    exp = q.size() > 0 ? q.pop_front() : 2'b11;
    check(nm, ans, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, "_hold"}, {out_valid, busy, ans}, {2'b11, exp});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_release"}, {out_valid, in_ready, busy}, 3'b010);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    tbl[0]  = '{16'h0005, 16'h0003, CMP_GT};
    tbl[1]  = '{16'hFFFF, 16'h0001, CMP_LT};
    tbl[2]  = '{16'h8000, 16'h7FFF, CMP_LT};
    tbl[3]  = '{16'h1234, 16'h1234, CMP_EQ};
    tbl[4]  = '{16'h1235, 16'h1234, CMP_GT};
    tbl[5]  = '{16'h0000, 16'h0000, CMP_EQ};
    tbl[6]  = '{16'h7FFF, 16'h8000, CMP_GT};
    tbl[7]  = '{16'hFFFE, 16'hFFFF, CMP_LT};
    tbl[8]  = '{16'h8000, 16'h8000, CMP_EQ};
    tbl[9]  = '{16'h0000, 16'hFFFF, CMP_GT};
    tbl[10] = '{16'h1234, 16'h0234, CMP_GT};
    tbl[11] = '{16'h8001, 16'h8000, CMP_GT};
    repeat (3) @(negedge clk);
    check("reset_state", {in_ready, out_valid, busy, ans}, 5'b10000);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].r);
      get_result($sformatf("vec%0d", i), W, 0);
    end
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = (i % 3 == 0) ? ra ^ W'(1 << (i * 2)) : W'($urandom);
      send(ra, rb, model(ra, rb));
      get_result($sformatf("rand%0d", i), W, 0);
    end
    out_ready = 1'b0;
    send(16'h0040, 16'hFFC0, CMP_GT);
    get_result("backpressure", W, 5);
    send(16'h0002, 16'h0001, CMP_GT);
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    a = 16'h0000;
    b = 16'h7FFF;
    @(negedge clk);
    check("busy_in_ready", in_ready, 0);
    in_valid = 1'b0;
    get_result("ignored_in_valid", W - 4, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= int'(out_valid);
    end
    check("no_second_result", {seen[0], busy}, 2'b00);
    send(16'h1111, 16'h2222, CMP_LT);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_run_reset", {in_ready, out_valid, busy}, 3'b100);
    rst = 1'b0;
    q.delete();
    send(16'h0002, 16'h0009, CMP_LT);
    get_result("after_reset", W, 0);
`ifdef SERIAL_CMP_UNSIGNED_EN
    is_signed = 1'b0;
    send(16'h8000, 16'h7FFF, CMP_GT);
    get_result("unsigned_extreme", W, 0);
    is_signed = 1'b1;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
